rr_grant_arbiter8: RTL and testbench



---
 rtl/arb_pkg.sv | 12 +
 rtl/decoder3to8.sv | 15 +
 rtl/rr_grant_arbiter8.sv | 111 +++++++++++
 tb/tb_rr_grant_arbiter8.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin grant arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage : arb_pkg

// File: rtl/decoder3to8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module decoder3to8 (
    input  logic [2:0] in,
    input  logic       en,
    output logic [7:0] out
);

    always_comb begin
        out = 8'h00;
        if (en) begin
            out = 8'h01 << in;
        end
    end

endmodule : decoder3to8

// File: rtl/rr_grant_arbiter8.sv
// Round-robin arbiter for 8 requesters with tenure hold limit and forced
// preemption; drives decoder3to8 to form the one-hot grant vector.
module rr_grant_arbiter8
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_en,
    output logic [N_REQ-1:0]   gnt,
    output logic               busy,
    output logic               timeout
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 1;

    arb_state_t         state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   gnt_idx_nxt;
    logic               gnt_en_nxt;
    logic               timeout_nxt;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
    logic               hold_limit;

    // First set request scanning ptr, ptr+1, ... ptr+7 (mod 8); descending
    // loop leaves the nearest hit as the final assignment.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] p);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        pick = p;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'(p + IDX_W'(k));
            if (r[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

    assign hold_limit = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

    // State register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            gnt_idx  <= '0;
            gnt_en   <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            gnt_idx  <= gnt_idx_nxt;
            gnt_en   <= gnt_en_nxt;
            timeout  <= timeout_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Next-state: pick a winner in IDLE, end tenure on release or hold limit
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        gnt_idx_nxt  = gnt_idx;
        gnt_en_nxt   = gnt_en;
        timeout_nxt  = 1'b0;
        hold_cnt_nxt = hold_cnt;

        unique case (state)
            IDLE: begin
                if (|req) begin
                    gnt_idx_nxt  = rr_pick(req, ptr);
                    gnt_en_nxt   = 1'b1;
                    hold_cnt_nxt = '0;
                    state_nxt    = OWN;
                end
            end
            OWN: begin
                if (hold_cnt != '1) begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
                if (!req[gnt_idx] || hold_limit) begin
                    gnt_en_nxt  = 1'b0;
                    ptr_nxt     = IDX_W'(gnt_idx + IDX_W'(1));
                    state_nxt   = IDLE;
                    timeout_nxt = req[gnt_idx];
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from registered state
    always_comb begin
        busy = (state == OWN);
    end

    decoder3to8 u_dec (
        .in  (gnt_idx),
        .en  (gnt_en),
        .out (gnt)
    );

endmodule : rr_grant_arbiter8

// File: tb/tb_rr_grant_arbiter8.sv
// Directed bench for rr_grant_arbiter8 with a tenure-level reference model.
module tb_rr_grant_arbiter8;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [2:0] gnt_idx;
    logic       gnt_en;
    logic [7:0] gnt;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    rr_grant_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt_idx (gnt_idx),
        .gnt_en  (gnt_en),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the resource, how many cycles they have held it,
    // and where the next search starts.
    int m_ptr = 0;
    int m_idx = 0;
    int m_len = 0;
    bit m_en  = 1'b0;
    bit m_to  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        int w;
        if (!rst_n) begin
            m_ptr <= 0; m_idx <= 0; m_len <= 0; m_en <= 1'b0; m_to <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (!m_en) begin
                if (req != 8'h00) begin
                    w = -1;
                    for (int k = 0; k < 8; k++)
                        if (w < 0 && req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
                    m_idx <= w;
                    m_en  <= 1'b1;
                    m_len <= 1;
                end
            end else if (!req[m_idx]) begin
                m_en  <= 1'b0;
                m_ptr <= (m_idx + 1) % 8;
            end else if (m_len == MAX_HOLD) begin
                m_en  <= 1'b0;
                m_to  <= 1'b1;
                m_ptr <= (m_idx + 1) % 8;
            end else begin
                m_len <= m_len + 1;
            end
        end
    end

    logic [7:0] exp_gnt;
    always @(negedge clk) begin
        if (check_en && rst_n === 1'b1) begin
            exp_gnt = m_en ? (8'h01 << m_idx) : 8'h00;
            chk("cyc_gnt",     32'(gnt),     32'(exp_gnt));
            chk("cyc_gnt_idx", 32'(gnt_idx), 32'(m_idx));
            chk("cyc_gnt_en",  32'(gnt_en),  32'(m_en));
            chk("cyc_busy",    32'(busy),    32'(m_en));
            chk("cyc_timeout", 32'(timeout), 32'(m_to));
            chk("cyc_onehot0", 32'($onehot0(gnt)), 32'd1);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt();
        int i;
        i = 0;
        while (gnt_en !== 1'b1 && i < 40) begin
            @(negedge clk);
            i++;
        end
        if (gnt_en !== 1'b1) chk("grant_wait_expired", 32'(gnt_en), 32'd1);
    endtask

    task automatic measure(output int idx, output int len);
        wait_gnt();
        idx = int'(gnt_idx);
        len = 0;
        while (gnt_en === 1'b1 && len < 100) begin
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        int idx, len, cur;
        rst_n = 1'b0;
        req   = 8'hFF;
        #1 check_en = 1'b1;

        // Reset with all requests high
        step(2);
        chk("rst_gnt",     32'(gnt),     32'h00);
        chk("rst_gnt_en",  32'(gnt_en),  32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_gnt_idx", 32'(gnt_idx), 32'd0);
        rst_n = 1'b1;
        req   = 8'h00;
        step(1);

        // Single requester, then pointer advances past it
        req = 8'h04;
        step(1);
        chk("single_gnt",  32'(gnt),     32'h04);
        chk("single_idx",  32'(gnt_idx), 32'd2);
        req = 8'h00;
        step(1);
        chk("single_rel_gnt", 32'(gnt),     32'h00);
        chk("single_rel_idx", 32'(gnt_idx), 32'd2);
        req = 8'h0C;
        step(1);
        chk("ptr3_gnt", 32'(gnt), 32'h08);
        req = 8'h00;
        step(2);

        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;

        // Rotation with all requesting, two-cycle tenures
        req = 8'hFF;
        wait_gnt();
        for (int k = 0; k < 9; k++) begin
            chk("rot_idx", 32'(gnt_idx), 32'(k % 8));
            cur = int'(gnt_idx);
            step(1);
            req[cur] = 1'b0;
            step(1);
            chk("rot_gap", 32'(gnt_en), 32'd0);
            req = 8'hFF;
            step(1);
        end
        req = 8'h00;
        step(2);

        // Hold-limit preemption of a sole requester
        req = 8'h01;
        measure(idx, len);
        chk("to_idx",     32'(idx),     32'd0);
        chk("to_len",     32'(len),     32'(MAX_HOLD));
        chk("to_pulse",   32'(timeout), 32'd1);
        chk("to_dead",    32'(gnt_en),  32'd0);
        step(1);
        chk("to_regrant", 32'(gnt),     32'h01);
        chk("to_clear",   32'(timeout), 32'd0);
        req = 8'h00;
        step(2);

        // Preemption fairness between agents 7 and 0, starting at ptr=7
        req = 8'h40;
        step(1);
        req = 8'h00;
        step(2);
        req = 8'h81;
        measure(idx, len);
        chk("fair1_idx", 32'(idx), 32'd7);
        chk("fair1_len", 32'(len), 32'(MAX_HOLD));
        measure(idx, len);
        chk("fair2_idx", 32'(idx), 32'd0);
        chk("fair2_len", 32'(len), 32'(MAX_HOLD));
        measure(idx, len);
        chk("fair3_idx", 32'(idx), 32'd7);
        chk("fair3_len", 32'(len), 32'(MAX_HOLD));
        req = 8'h00;
        step(2);

        // Asynchronous reset in the middle of a tenure
        req = 8'h20;
        wait_gnt();
        chk("mid_gnt", 32'(gnt), 32'h20);
        step(1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_gnt",    32'(gnt),     32'h00);
        chk("async_gnt_en", 32'(gnt_en),  32'd0);
        chk("async_busy",   32'(busy),    32'd0);
        chk("async_idx",    32'(gnt_idx), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'hFF;
        step(1);
        chk("post_rst_gnt", 32'(gnt), 32'h01);
        req = 8'h00;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1);
    end

endmodule : tb_rr_grant_arbiter8
